// File: rtl/shift_deser_if.sv
// Serial-in / parallel-out bundle for shift_deser: bit strobe side plus the
// ready/valid word output side. The deserializer uses the slave modport.
interface shift_deser_if #(
  parameter int WIDTH = 4
);
  logic             sin;
  logic             sin_valid;
  logic             start;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             overrun;
  logic             perr;

  modport slave (
    input  sin, sin_valid, start, dout_ready,
    output dout, dout_valid, overrun, perr
  );

  modport master (
    output sin, sin_valid, start, dout_ready,
    input  dout, dout_valid, overrun, perr
  );
endinterface

// File: rtl/shift_deser.sv
// LSB-first serial-to-parallel deserializer with a one-word ready/valid output.
// Optional even-parity bit per word is enabled by defining SHIFT_DESER_PARITY_EN.
module shift_deser #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           resetn,
  shift_deser_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef SHIFT_DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               dvld_q, dvld_d;
  logic               ovr_q, ovr_d;
  logic               done;
  logic [WIDTH-1:0]   word;
  logic [WIDTH-1:0]   shifted;
`ifdef SHIFT_DESER_PARITY_EN
  logic               perr_q, perr_d;
  logic               word_perr;
`endif

  // New bits enter at the MSB so the first bit of a frame ends up in bit 0.
  assign shifted = {bus.sin, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    dvld_d  = dvld_q;
    ovr_d   = 1'b0;
    done    = 1'b0;
    word    = shifted;
`ifdef SHIFT_DESER_PARITY_EN
    perr_d    = perr_q;
    word_perr = 1'b0;
`endif

    if (bus.sin_valid) begin
      if (bus.start) begin
        state_d = RECV;
        cnt_d   = CNT_W'(1);
        shreg_d = {bus.sin, {(WIDTH-1){1'b0}}};
      end else begin
        case (state_q)
          RECV: begin
            shreg_d = shifted;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              cnt_d = '0;
`ifdef SHIFT_DESER_PARITY_EN
              state_d = PAR;
`else
              state_d = IDLE;
              done    = 1'b1;
`endif
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
`ifdef SHIFT_DESER_PARITY_EN
          PAR: begin
            state_d   = IDLE;
            done      = 1'b1;
            word      = shreg_q;
            word_perr = (^shreg_q) ^ bus.sin;
          end
`endif
          default: ;
        endcase
      end
    end

    // A finished word only lands if the output slot is empty or being drained.
    if (done) begin
      if (!dvld_q || bus.dout_ready) begin
        dout_d = word;
        dvld_d = 1'b1;
`ifdef SHIFT_DESER_PARITY_EN
        perr_d = word_perr;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (dvld_q && bus.dout_ready) begin
      dvld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
      ovr_q   <= ovr_d;
`ifdef SHIFT_DESER_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dvld_q;
  assign bus.overrun    = ovr_q;
`ifdef SHIFT_DESER_PARITY_EN
  assign bus.perr       = perr_q;
`else
  assign bus.perr       = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deser.sv
// Randomized plus directed bench for shift_deser against a frame-level model
// that collects bits in a queue and forms words arithmetically.
module tb_shift_deser;
  localparam int WIDTH = 4;
`ifdef SHIFT_DESER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  shift_deser_if #(.WIDTH(WIDTH)) bus ();
  shift_deser #(.WIDTH(WIDTH)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  bit          frame_q[$];
  bit          in_frame;
  logic [31:0] m_dout;
  bit          m_vld, m_ovr, m_perr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    in_frame = 1'b0;
    m_dout   = '0;
    m_vld    = 1'b0;
    m_ovr    = 1'b0;
    m_perr   = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit v, input bit st, input bit rdy);
    bit          done = 1'b0;
    logic [31:0] w    = '0;
    bit          p    = 1'b0;
    if (v) begin
      if (st) begin
        frame_q.delete();
        frame_q.push_back(s);
        in_frame = 1'b1;
      end else if (in_frame) begin
        frame_q.push_back(s);
      end
    end
    if (in_frame && frame_q.size() == NBITS) begin
      done = 1'b1;
      for (int i = 0; i < WIDTH; i++) w = w + (32'(frame_q[i]) << i);
`ifdef SHIFT_DESER_PARITY_EN
      for (int i = 0; i < NBITS; i++) p = p ^ frame_q[i];
`endif
      frame_q.delete();
      in_frame = 1'b0;
    end
    m_ovr = 1'b0;
    if (done) begin
      if (!m_vld || rdy) begin
        m_dout = w;
        m_vld  = 1'b1;
        m_perr = p;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_vld && rdy) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("dout",       32'(bus.dout),       m_dout);
    check("dout_valid", 32'(bus.dout_valid), 32'(m_vld));
    check("overrun",    32'(bus.overrun),    32'(m_ovr));
    check("perr",       32'(bus.perr),       32'(m_perr));
  endtask

  // Drive one clock worth of inputs (called just after a falling edge).
  task automatic cycle(input bit s, input bit v, input bit st, input bit rdy);
    bus.sin        = s;
    bus.sin_valid  = v;
    bus.start      = st;
    bus.dout_ready = rdy;
    model_step(s, v, st, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int maxgap, input bit rdy);
    for (int i = 0; i < WIDTH; i++) begin
      repeat ($urandom_range(maxgap, 0)) cycle(1'($urandom), 1'b0, 1'($urandom), rdy);
      cycle(w[i], 1'b1, (i == 0), rdy);
    end
`ifdef SHIFT_DESER_PARITY_EN
    cycle(^w, 1'b1, 1'b0, rdy);
`endif
  endtask

  task automatic do_reset();
    bus.sin_valid = 1'b0;
    bus.start     = 1'b0;
    resetn        = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn         = 1'b0;
    bus.sin        = 1'b0;
    bus.sin_valid  = 1'b0;
    bus.start      = 1'b0;
    bus.dout_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_dout", 32'(bus.dout), 32'h0);
    check("rst_vld",  32'(bus.dout_valid), 32'h0);
    check("rst_ovr",  32'(bus.overrun), 32'h0);
    check("rst_perr", 32'(bus.perr), 32'h0);
    resetn = 1'b1;

    // Basic frame, consumer always ready
    send_word(4'hD, 0, 1'b1);
    check("basic_dout", 32'(bus.dout), 32'hD);
    check("basic_vld",  32'(bus.dout_valid), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("basic_drain", 32'(bus.dout_valid), 32'h0);

    // Strobe gaps between bits
    send_word(4'h6, 3, 1'b1);
    check("gap_dout", 32'(bus.dout), 32'h6);
    check("gap_vld",  32'(bus.dout_valid), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-pressure: second word dropped with an overrun pulse
    send_word(4'hA, 0, 1'b0);
    send_word(4'h5, 0, 1'b0);
    check("ovr_dout", 32'(bus.dout), 32'hA);
    check("ovr_pulse", 32'(bus.overrun), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_drain", 32'(bus.dout_valid), 32'h0);
    check("ovr_once",  32'(bus.overrun), 32'h0);

    // Restart abandons the partial word
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    send_word(4'hF, 0, 1'b1);
    check("abort_dout", 32'(bus.dout), 32'hF);
    check("abort_ovr",  32'(bus.overrun), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-frame; bits without start are ignored afterwards
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < NBITS; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("nostart_vld", 32'(bus.dout_valid), 32'h0);
    send_word(4'h9, 1, 1'b1);
    check("post_rst_dout", 32'(bus.dout), 32'h9);

`ifdef SHIFT_DESER_PARITY_EN
    // Data 7 with a good and then a bad parity bit
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("par_ok_dout", 32'(bus.dout), 32'h7);
    check("par_ok_perr", 32'(bus.perr), 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("par_bad_dout", 32'(bus.dout), 32'h7);
    check("par_bad_perr", 32'(bus.perr), 32'h1);
`endif

    // Random traffic with occasional restarts, stalls and resets
    for (int n = 0; n < 3000; n++) begin
      bit v, st, rdy;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        v   = ($urandom_range(0, 99) < 60);
        st  = ($urandom_range(0, 99) < 15);
        rdy = ($urandom_range(0, 99) < 70);
        cycle(1'($urandom), v, st, rdy);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
